// File: rtl/hazard_ctrl_if.sv
// Decode-side handshake between the pipeline (master) and the hazard sequencer (slave).
interface hazard_ctrl_if;
  logic        id_valid_i;
  logic [31:0] id_instr_i;
  logic        redirect_i;
  logic        stall_o;
  logic        flush_o;
  logic        ex_hold_o;
  logic [1:0]  fwd_rs1_sel_o;
  logic [1:0]  fwd_rs2_sel_o;
  logic [4:0]  ex_rd_o;
  logic [4:0]  mem_rd_o;
  logic [4:0]  wb_rd_o;
  logic        muldiv_busy_o;

  modport master (
    output id_valid_i, id_instr_i, redirect_i,
    input  stall_o, flush_o, ex_hold_o, fwd_rs1_sel_o, fwd_rs2_sel_o,
           ex_rd_o, mem_rd_o, wb_rd_o, muldiv_busy_o
  );

  modport slave (
    input  id_valid_i, id_instr_i, redirect_i,
    output stall_o, flush_o, ex_hold_o, fwd_rs1_sel_o, fwd_rs2_sel_o,
           ex_rd_o, mem_rd_o, wb_rd_o, muldiv_busy_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// EX-stage hazard sequencer: load-use stall, registered forward selects, redirect flush, MUL/DIV hold.
// Stall/flush/hold are combinational from current state; tags and selects update on each edge.
module hazard_ctrl #(
  parameter int MULDIV_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  localparam int CW = ($clog2(MULDIV_LAT + 1) > 3) ? $clog2(MULDIV_LAT + 1) : 3;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    ex_rd, mem_rd, wb_rd;
  logic          ex_load;
  logic [1:0]    sel1, sel2;

  logic [6:0] opc;
  logic [4:0] rs1, rs2, rd, dec_rd;
  logic       use_rs1, use_rs2, wr_rd, is_load, is_md;
  logic       busy, ld_haz;
  logic       unused_funct3;

  assign opc           = bus.id_instr_i[6:0];
  assign rd            = bus.id_instr_i[11:7];
  assign rs1           = bus.id_instr_i[19:15];
  assign rs2           = bus.id_instr_i[24:20];
  assign unused_funct3 = ^bus.id_instr_i[14:12];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr_rd   = 1'b0;
    case (opc)
      OP_R:                begin use_rs1 = 1'b1; use_rs2 = 1'b1; wr_rd = 1'b1; end
      OP_I, OP_LOAD,
      OP_JALR:             begin use_rs1 = 1'b1; wr_rd = 1'b1; end
      OP_STORE, OP_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_LUI, OP_AUIPC,
      OP_JAL:              wr_rd = 1'b1;
      default:             ;
    endcase
  end

  assign dec_rd  = wr_rd ? rd : 5'd0;
  assign is_load = (opc == OP_LOAD);
  assign is_md   = (opc == OP_R) && (bus.id_instr_i[31:25] == 7'b0000001);

  assign busy   = (state == BUSY);
  assign ld_haz = bus.id_valid_i && ex_load && (ex_rd != 5'd0) &&
                  ((use_rs1 && rs1 == ex_rd) || (use_rs2 && rs2 == ex_rd));

  // Nearest producer wins: the EX instruction moves to MEM, the MEM one to WB.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] src,
                                         input logic [4:0] exr, input logic [4:0] memr);
    if (!used || src == 5'd0) return 2'b00;
    if (src == exr)           return 2'b01;
    if (src == memr)          return 2'b10;
    return 2'b00;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ex_rd   <= 5'd0;
      ex_load <= 1'b0;
      mem_rd  <= 5'd0;
      wb_rd   <= 5'd0;
      sel1    <= 2'b00;
      sel2    <= 2'b00;
    end else if (bus.redirect_i) begin
      state   <= IDLE;
      cnt     <= '0;
      ex_rd   <= 5'd0;
      ex_load <= 1'b0;
      mem_rd  <= ex_rd;
      wb_rd   <= mem_rd;
      sel1    <= 2'b00;
      sel2    <= 2'b00;
    end else if (busy) begin
      // EX keeps its tag and selects; the MUL/DIV unit already latched its operands.
      mem_rd <= 5'd0;
      wb_rd  <= mem_rd;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) state <= IDLE;
    end else if (ld_haz) begin
      ex_rd   <= 5'd0;
      ex_load <= 1'b0;
      mem_rd  <= ex_rd;
      wb_rd   <= mem_rd;
      sel1    <= 2'b00;
      sel2    <= 2'b00;
    end else begin
      mem_rd <= ex_rd;
      wb_rd  <= mem_rd;
      if (bus.id_valid_i) begin
        ex_rd   <= dec_rd;
        ex_load <= is_load;
        sel1    <= fwd_sel(use_rs1, rs1, ex_rd, mem_rd);
        sel2    <= fwd_sel(use_rs2, rs2, ex_rd, mem_rd);
        if (is_md && MULDIV_LAT > 1) begin
          cnt   <= CW'(MULDIV_LAT - 1);
          state <= BUSY;
        end
      end else begin
        ex_rd   <= 5'd0;
        ex_load <= 1'b0;
        sel1    <= 2'b00;
        sel2    <= 2'b00;
      end
    end
  end

  assign bus.stall_o       = !bus.redirect_i && (busy || ld_haz);
  assign bus.flush_o       = bus.redirect_i;
  assign bus.ex_hold_o     = busy;
  assign bus.muldiv_busy_o = busy;
  assign bus.fwd_rs1_sel_o = sel1;
  assign bus.fwd_rs2_sel_o = sel2;
  assign bus.ex_rd_o       = ex_rd;
  assign bus.mem_rd_o      = mem_rd;
  assign bus.wb_rd_o       = wb_rd;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  hazard_ctrl_if bus();

  hazard_ctrl #(.MULDIV_LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       stall;
    logic       flush;
    logic       hold;
    logic       busy;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [4:0] ex;
    logic [4:0] mem;
    logic [4:0] wb;
  } exp_t;

  localparam logic [31:0] ADD3   = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] SUB5   = 32'h404182B3; // sub x5,x3,x4
  localparam logic [31:0] LW1    = 32'h00012083; // lw  x1,0(x2)
  localparam logic [31:0] ADD311 = 32'h001081B3; // add x3,x1,x1
  localparam logic [31:0] MUL6   = 32'h02208333; // mul x6,x1,x2
  localparam logic [31:0] ADD366 = 32'h006301B3; // add x3,x6,x6
  localparam logic [31:0] ADDX0  = 32'h00208033; // add x0,x1,x2
  localparam logic [31:0] ADD300 = 32'h000001B3; // add x3,x0,x0

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic exp_t mk(input logic st, input logic fl, input logic ho, input logic bu,
                              input logic [1:0] a, input logic [1:0] b,
                              input logic [4:0] e, input logic [4:0] m, input logic [4:0] w);
    exp_t r;
    r.stall = st; r.flush = fl; r.hold = ho; r.busy = bu;
    r.s1 = a; r.s2 = b; r.ex = e; r.mem = m; r.wb = w;
    return r;
  endfunction

  task automatic step(input logic v, input logic [31:0] ins, input logic redir,
                      input logic r, input exp_t e);
    @(posedge clk);
    #1;
    rst            = r;
    bus.id_valid_i = v;
    bus.id_instr_i = ins;
    bus.redirect_i = redir;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    exp_t a;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      a.stall = bus.stall_o;       a.flush = bus.flush_o;
      a.hold  = bus.ex_hold_o;     a.busy  = bus.muldiv_busy_o;
      a.s1    = bus.fwd_rs1_sel_o; a.s2    = bus.fwd_rs2_sel_o;
      a.ex    = bus.ex_rd_o;       a.mem   = bus.mem_rd_o;
      a.wb    = bus.wb_rd_o;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL vec%0d got stall=%b flush=%b hold=%b busy=%b s1=%b s2=%b ex=%0d mem=%0d wb=%0d | want stall=%b flush=%b hold=%b busy=%b s1=%b s2=%b ex=%0d mem=%0d wb=%0d",
                 n_cmp, a.stall, a.flush, a.hold, a.busy, a.s1, a.s2, a.ex, a.mem, a.wb,
                 e.stall, e.flush, e.hold, e.busy, e.s1, e.s2, e.ex, e.mem, e.wb);
      end
    end
  end

  initial begin
    bus.id_valid_i = 1'b0;
    bus.id_instr_i = 32'h0;
    bus.redirect_i = 1'b0;

    // reset state
    step(0, 0,      0, 0, mk(0,0,0,0, 2'd0,2'd0, 0,0,0));
    // ALU -> ALU forwarding from MEM
    step(1, ADD3,   0, 0, mk(0,0,0,0, 2'd0,2'd0, 0,0,0));
    step(1, SUB5,   0, 0, mk(0,0,0,0, 2'd0,2'd0, 3,0,0));
    step(0, 0,      0, 0, mk(0,0,0,0, 2'd1,2'd0, 5,3,0));
    // load-use: one stall, then WB forwarding on both sources
    step(1, LW1,    0, 0, mk(0,0,0,0, 2'd0,2'd0, 0,5,3));
    step(1, ADD311, 0, 0, mk(1,0,0,0, 2'd0,2'd0, 1,0,5));
    step(1, ADD311, 0, 0, mk(0,0,0,0, 2'd0,2'd0, 0,1,0));
    step(0, 0,      0, 0, mk(0,0,0,0, 2'd2,2'd2, 3,0,1));
    // MUL occupies EX for 4 cycles, dependent add issues after and forwards from MEM
    step(1, MUL6,   0, 0, mk(0,0,0,0, 2'd0,2'd0, 0,3,0));
    step(1, ADD366, 0, 0, mk(1,0,1,1, 2'd0,2'd0, 6,0,3));
    step(1, ADD366, 0, 0, mk(1,0,1,1, 2'd0,2'd0, 6,0,0));
    step(1, ADD366, 0, 0, mk(1,0,1,1, 2'd0,2'd0, 6,0,0));
    step(1, ADD366, 0, 0, mk(0,0,0,0, 2'd0,2'd0, 6,0,0));
    step(0, 0,      0, 0, mk(0,0,0,0, 2'd1,2'd1, 3,6,0));
    // x0 destination / x0 sources never forward
    step(1, ADDX0,  0, 0, mk(0,0,0,0, 2'd0,2'd0, 0,3,6));
    step(1, ADD300, 0, 0, mk(0,0,0,0, 2'd0,2'd0, 0,0,3));
    step(0, 0,      0, 0, mk(0,0,0,0, 2'd0,2'd0, 3,0,0));
    // redirect beats load-use
    step(1, LW1,    0, 0, mk(0,0,0,0, 2'd0,2'd0, 0,3,0));
    step(1, ADD311, 1, 0, mk(0,1,0,0, 2'd0,2'd0, 1,0,3));
    step(0, 0,      0, 0, mk(0,0,0,0, 2'd0,2'd0, 0,1,0));
    // reset in the second BUSY cycle aborts
    step(1, MUL6,   0, 0, mk(0,0,0,0, 2'd0,2'd0, 0,0,1));
    step(0, 0,      0, 0, mk(1,0,1,1, 2'd0,2'd0, 6,0,0));
    step(0, 0,      0, 1, mk(1,0,1,1, 2'd0,2'd0, 6,0,0));
    step(1, ADD3,   0, 0, mk(0,0,0,0, 2'd0,2'd0, 0,0,0));
    step(0, 0,      0, 0, mk(0,0,0,0, 2'd0,2'd0, 3,0,0));
    step(0, 0,      0, 0, mk(0,0,0,0, 2'd0,2'd0, 0,3,0));
    // back-to-back MUL: second issues the cycle BUSY clears
    step(1, MUL6,   0, 0, mk(0,0,0,0, 2'd0,2'd0, 0,0,3));
    step(1, MUL6,   0, 0, mk(1,0,1,1, 2'd0,2'd0, 6,0,0));
    step(1, MUL6,   0, 0, mk(1,0,1,1, 2'd0,2'd0, 6,0,0));
    step(1, MUL6,   0, 0, mk(1,0,1,1, 2'd0,2'd0, 6,0,0));
    step(1, MUL6,   0, 0, mk(0,0,0,0, 2'd0,2'd0, 6,0,0));
    step(0, 0,      0, 0, mk(1,0,1,1, 2'd0,2'd0, 6,6,0));
    step(0, 0,      0, 0, mk(1,0,1,1, 2'd0,2'd0, 6,0,6));

    repeat (4) @(posedge clk);
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d want=0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
